dcf77_frame_encoder: RTL and testbench
======================================

// Module: dcf77_frame_encoder
// PURPOSE
//  Generates a DCF77-format time-code pulse train from parallel BCD time/date inputs: the transmit side of the
//  DCF77 link. Drives a local test/emulation antenna line or feeds the receiver clock generator's DCF input in
//  closed-loop lab setups. Emits one 59-bit frame per minute: amplitude-reduction pulses at each second start
//  and no pulse in second 59, which serves as the minute marker.
// PARAMETERS
//  FREQUENCY  10000000  clk frequency in Hz; one second = FREQUENCY cycles
//  SHORT_MS   100       low-pulse width for bit value 0, in ms
//  LONG_MS    200       low-pulse width for bit value 1, in ms
//  (derived) SHORT_TICKS = FREQUENCY*SHORT_MS/1000, LONG_TICKS = FREQUENCY*LONG_MS/1000; require LONG_TICKS < FREQUENCY
// PORTS
//  clk             in   1  system clock
//  nReset          in   1  reset, asynchronous, active-low
//  ENABLE_in       in   1  transmit enable (level)
//  MINUTE_in       in   7  BCD minute 00-59
//  HOUR_in         in   6  BCD hour 00-23
//  DAY_in          in   6  BCD day of month 01-31
//  WEEKDAY_in      in   3  weekday 1-7 (1 = Monday)
//  MONTH_in        in   5  BCD month 01-12
//  YEAR_in         in   8  BCD year 00-99
//  DST_in          in   1  1 = summer time (CEST)
//  DCF_SIGNAL_out  out  1  encoded signal; idle 1, 0 during carrier-reduction pulse
//  SECOND_out      out  6  index of the second currently being sent (0-59)
//  SEC_TICK_out    out  1  1-cycle pulse at the start of each second
//  FRAME_DONE_out  out  1  1-cycle pulse in the last cycle of second 59
// BEHAVIOUR
//  Reset: DCF_SIGNAL_out=1, SECOND_out=0, SEC_TICK_out=0, FRAME_DONE_out=0; tick counter=0, frame register=0.
//  Counters: tick 0..FREQUENCY-1 and sec 0..59 advance every cycle while ENABLE_in=1; tick wraps to 0 and increments sec;
//    sec wraps 59->0.
//  ENABLE_in=0: tick and sec held at 0, DCF_SIGNAL_out=1 the next cycle (aborts any pulse), pulse outputs 0.
//    The first enabled cycle is tick 0 of second 0.
//  Frame latch: inputs are captured into a 59-bit frame register in the cycle with sec=0 and tick=0. Input changes
//    at any other time affect only the next frame.
//  Frame bits: 0..16=0; 17=DST_in; 18=!DST_in; 19=0; 20=1 (start of time); 21-27 minute; 28 P1; 29-34 hour;
//    35 P2; 36-41 day; 42-44 weekday; 45-49 month; 50-57 year; 58 P3. Fields are sent LSB first.
//    Parity is even: P1 covers 21-27, P2 covers 29-34, P3 covers 36-57.
//    Inputs are not range-checked; illegal BCD values are sent unchanged.
//  Pulse: for sec 0..58, DCF_SIGNAL_out goes 0 one cycle after the tick=0 cycle. It stays 0 for exactly SHORT_TICKS
//    cycles (bit 0) or LONG_TICKS cycles (bit 1), then returns to 1.
//  Second 59: DCF_SIGNAL_out stays 1 for the whole second. The falling edge of sec 58 and the next falling edge
//    (sec 0) are therefore 2*FREQUENCY cycles apart.
//  SECOND_out, SEC_TICK_out and FRAME_DONE_out are registered with the same 1-cycle latency as DCF_SIGNAL_out.
//    SEC_TICK_out and the falling edge of DCF_SIGNAL_out coincide.
//  Async reset mid-frame: all outputs return to reset values immediately; the frame restarts at sec 0.
// TESTING (FREQUENCY=1000, SHORT_MS=100, LONG_MS=200)
//  Reset held, ENABLE_in=1 -> DCF_SIGNAL_out=1, SECOND_out=0, no tick pulses; release -> first falling edge 1 cycle later.
//  Enable with 12:34, day 17, weekday 5, month 08, year 18, DST=1 -> decoded bits 17/18=1/0, 20=1,
//    21-27=0010110 P1=1, 29-34=010010 P2=0, P3 = even parity of bits 36-57.
//  Measure low widths: bit 0 -> 100 cycles, bit 1 (e.g. bit 20) -> 200 cycles; tick spacing 1000 cycles.
//  Second 59 -> no falling edge, 2000 cycles between edges; FRAME_DONE_out high exactly 1 cycle before sec 0 tick.
//  Change MINUTE_in 34->35 at sec 30 -> current frame still carries 34; next frame carries 35.
//  Drop ENABLE_in during a bit-1 pulse (tick 50) -> DCF_SIGNAL_out=1 next cycle, SECOND_out=0;
//    re-enable -> fresh frame from sec 0.

Source files
------------

// File: rtl/dcf77_frame_encoder.sv
// DCF77 time-code transmitter: one 59-bit BCD frame per minute as carrier-reduction pulses.
// Latency 1 cycle from the internal tick/second counters to all outputs; no backpressure (free-running while enabled).
module dcf77_frame_encoder #(
    parameter int unsigned FREQUENCY = 10000000,
    parameter int unsigned SHORT_MS  = 100,
    parameter int unsigned LONG_MS   = 200
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       ENABLE_in,
    input  logic [6:0] MINUTE_in,
    input  logic [5:0] HOUR_in,
    input  logic [5:0] DAY_in,
    input  logic [2:0] WEEKDAY_in,
    input  logic [4:0] MONTH_in,
    input  logic [7:0] YEAR_in,
    input  logic       DST_in,
    output logic       DCF_SIGNAL_out,
    output logic [5:0] SECOND_out,
    output logic       SEC_TICK_out,
    output logic       FRAME_DONE_out
);
    localparam int unsigned   TW          = (FREQUENCY > 1) ? $clog2(FREQUENCY) : 1;
    localparam logic [TW-1:0] TICK_LAST   = TW'(FREQUENCY - 1);
    localparam logic [TW-1:0] SHORT_TICKS = TW'((64'(FREQUENCY) * 64'(SHORT_MS)) / 64'd1000);
    localparam logic [TW-1:0] LONG_TICKS  = TW'((64'(FREQUENCY) * 64'(LONG_MS)) / 64'd1000);
    localparam logic [5:0]    SEC_MARKER  = 6'd59;

    logic [TW-1:0] tick_q, tick_d;
    logic [5:0]    sec_q, sec_d;
    logic [58:0]   frame_q, frame_d;
    logic          dcf_q, dcf_d;
    logic [5:0]    second_q, second_d;
    logic          sec_tick_q, sec_tick_d;
    logic          frame_done_q, frame_done_d;

    logic [58:0]   frame_new;
    logic [63:0]   frame_pad;
    logic          bit_val;
    logic [TW-1:0] pulse_width;

    always_comb begin
        frame_new        = '0;
        frame_new[17]    = DST_in;
        frame_new[18]    = ~DST_in;
        frame_new[20]    = 1'b1;
        frame_new[27:21] = MINUTE_in;
        frame_new[28]    = ^MINUTE_in;
        frame_new[34:29] = HOUR_in;
        frame_new[35]    = ^HOUR_in;
        frame_new[41:36] = DAY_in;
        frame_new[44:42] = WEEKDAY_in;
        frame_new[49:45] = MONTH_in;
        frame_new[57:50] = YEAR_in;
        frame_new[58]    = ^{DAY_in, WEEKDAY_in, MONTH_in, YEAR_in};
    end

    always_comb begin
        tick_d       = tick_q;
        sec_d        = sec_q;
        frame_d      = frame_q;
        dcf_d        = 1'b1;
        second_d     = '0;
        sec_tick_d   = 1'b0;
        frame_done_d = 1'b0;
        // Padding keeps the per-second bit select in range for sec 59..63.
        frame_pad    = {5'b0, frame_q};
        bit_val      = frame_pad[sec_q];
        pulse_width  = bit_val ? LONG_TICKS : SHORT_TICKS;

        if (ENABLE_in) begin
            if (tick_q == TICK_LAST) begin
                tick_d = '0;
                sec_d  = (sec_q == SEC_MARKER) ? 6'd0 : sec_q + 6'd1;
            end else begin
                tick_d = tick_q + TW'(1);
            end
            // Bit 0 is always 0, so sec 0 may read the previous frame in its latch cycle.
            if (tick_q == '0 && sec_q == '0) begin
                frame_d = frame_new;
            end
            dcf_d        = !((sec_q != SEC_MARKER) && (tick_q < pulse_width));
            second_d     = sec_q;
            sec_tick_d   = (tick_q == '0);
            frame_done_d = (sec_q == SEC_MARKER) && (tick_q == TICK_LAST);
        end else begin
            tick_d = '0;
            sec_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            tick_q       <= '0;
            sec_q        <= '0;
            frame_q      <= '0;
            dcf_q        <= 1'b1;
            second_q     <= '0;
            sec_tick_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            sec_q        <= sec_d;
            frame_q      <= frame_d;
            dcf_q        <= dcf_d;
            second_q     <= second_d;
            sec_tick_q   <= sec_tick_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign DCF_SIGNAL_out = dcf_q;
    assign SECOND_out     = second_q;
    assign SEC_TICK_out   = sec_tick_q;
    assign FRAME_DONE_out = frame_done_q;

endmodule

// File: tb/tb_dcf77_frame_encoder.sv
// Bench for dcf77_frame_encoder: scoreboard of expected pulse widths per second, checked by a line monitor.
module tb_dcf77_frame_encoder;
    localparam int F     = 200;
    localparam int SHORT = F * 100 / 1000;
    localparam int LONG  = F * 200 / 1000;

    logic       clk;
    logic       nReset;
    logic       ENABLE_in;
    logic [6:0] MINUTE_in;
    logic [5:0] HOUR_in;
    logic [5:0] DAY_in;
    logic [2:0] WEEKDAY_in;
    logic [4:0] MONTH_in;
    logic [7:0] YEAR_in;
    logic       DST_in;
    logic       DCF_SIGNAL_out;
    logic [5:0] SECOND_out;
    logic       SEC_TICK_out;
    logic       FRAME_DONE_out;

    dcf77_frame_encoder #(.FREQUENCY(F), .SHORT_MS(100), .LONG_MS(200)) dut (
        .clk(clk), .nReset(nReset), .ENABLE_in(ENABLE_in),
        .MINUTE_in(MINUTE_in), .HOUR_in(HOUR_in), .DAY_in(DAY_in),
        .WEEKDAY_in(WEEKDAY_in), .MONTH_in(MONTH_in), .YEAR_in(YEAR_in),
        .DST_in(DST_in), .DCF_SIGNAL_out(DCF_SIGNAL_out), .SECOND_out(SECOND_out),
        .SEC_TICK_out(SEC_TICK_out), .FRAME_DONE_out(FRAME_DONE_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [58:0] model_frame(input logic [6:0] mi, input logic [5:0] hr,
                                                input logic [5:0] dy, input logic [2:0] wd,
                                                input logic [4:0] mo, input logic [7:0] yr,
                                                input logic dst);
        logic [58:0] f;
        f        = '0;
        f[17]    = dst;
        f[18]    = ~dst;
        f[20]    = 1'b1;
        f[27:21] = mi;
        f[28]    = ^mi;
        f[34:29] = hr;
        f[35]    = ^hr;
        f[41:36] = dy;
        f[44:42] = wd;
        f[49:45] = mo;
        f[57:50] = yr;
        f[58]    = ^{dy, wd, mo, yr};
        return f;
    endfunction

    int exp_q[$];

    task automatic push_frame(input logic [58:0] f);
        for (int i = 0; i < 59; i++) exp_q.push_back(f[i] ? LONG : SHORT);
    endtask

    function automatic logic [58:0] cur_model();
        return model_frame(MINUTE_in, HOUR_in, DAY_in, WEEKDAY_in, MONTH_in, YEAR_in, DST_in);
    endfunction

    // Line monitor: measures pulse widths, falling-edge spacing and frame-done placement.
    logic        mon_en = 1'b0;
    int          cyc = 0;
    logic        prev_dcf, have_fall, have_fd, prev_fd;
    int          fall_cyc, fall_sec, last_fall_cyc, last_fall_sec, fd_cyc, width;
    logic [58:0] rx_bits, last_frame;
    int          frame_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        if (!mon_en) begin
            prev_dcf  = 1'b1;
            have_fall = 1'b0;
            have_fd   = 1'b0;
            prev_fd   = 1'b0;
        end else begin
            if (prev_dcf && !DCF_SIGNAL_out) begin
                fall_cyc = cyc;
                fall_sec = int'(SECOND_out);
                chk("tick_at_fall", {63'd0, SEC_TICK_out}, 64'd1);
                if (have_fall)
                    chk("fall_gap", 64'(cyc - last_fall_cyc), 64'((last_fall_sec == 58) ? 2 * F : F));
                have_fall     = 1'b1;
                last_fall_cyc = cyc;
                last_fall_sec = fall_sec;
            end
            if (!prev_dcf && DCF_SIGNAL_out) begin
                width = cyc - fall_cyc;
                if (exp_q.size() == 0) chk("sb_underflow", 64'(width), 64'd0);
                else                   chk("pulse_width", 64'(width), 64'(exp_q.pop_front()));
                if (fall_sec < 59) rx_bits[fall_sec] = (width > (SHORT + LONG) / 2);
                if (fall_sec == 58) begin
                    last_frame = rx_bits;
                    frame_cnt++;
                end
            end
            if (FRAME_DONE_out) begin
                chk("frame_done_sec", 64'(SECOND_out), 64'd59);
                chk("frame_done_len", {63'd0, prev_fd}, 64'd0);
                fd_cyc  = cyc;
                have_fd = 1'b1;
            end
            if (SEC_TICK_out && SECOND_out == 6'd0 && have_fd) begin
                chk("frame_done_pos", 64'(cyc - fd_cyc), 64'd1);
                have_fd = 1'b0;
            end
            prev_fd  = FRAME_DONE_out;
            prev_dcf = DCF_SIGNAL_out;
        end
    end

    task automatic wait_tick_sec(input int s);
        bit found = 0;
        for (int i = 0; i < 61 * F && !found; i++) begin
            @(negedge clk);
            if (SEC_TICK_out && int'(SECOND_out) == s) found = 1;
        end
        chk("wait_tick_sec_timeout", {63'd0, found}, 64'd1);
    endtask

    task automatic wait_frame(input int n);
        bit found = 0;
        for (int i = 0; i < 62 * F && !found; i++) begin
            @(negedge clk);
            if (frame_cnt >= n) found = 1;
        end
        chk("wait_frame_timeout", {63'd0, found}, 64'd1);
    endtask

    task automatic check_restart(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_dcf"}, {63'd0, DCF_SIGNAL_out}, 64'd0);
        chk({tag, "_tick"}, {63'd0, SEC_TICK_out}, 64'd1);
        chk({tag, "_sec"}, 64'(SECOND_out), 64'd0);
    endtask

    logic [58:0] fa, fb, fc;
    int          anomalies;

    initial begin
        nReset     = 1'b0;
        ENABLE_in  = 1'b1;
        MINUTE_in  = 7'h34;
        HOUR_in    = 6'h12;
        DAY_in     = 6'h17;
        WEEKDAY_in = 3'd5;
        MONTH_in   = 5'h08;
        YEAR_in    = 8'h18;
        DST_in     = 1'b1;
        anomalies  = 0;

        // Reset held with enable high: line idle, no ticks.
        repeat (20) begin
            @(negedge clk);
            if (!DCF_SIGNAL_out || SEC_TICK_out || FRAME_DONE_out || SECOND_out != 6'd0) anomalies++;
        end
        chk("rst_dcf", {63'd0, DCF_SIGNAL_out}, 64'd1);
        chk("rst_sec", 64'(SECOND_out), 64'd0);
        chk("rst_tick", {63'd0, SEC_TICK_out}, 64'd0);
        chk("rst_fdone", {63'd0, FRAME_DONE_out}, 64'd0);
        chk("rst_quiet", 64'(anomalies), 64'd0);

        #1;
        fa = cur_model();
        push_frame(fa);
        mon_en = 1'b1;
        nReset = 1'b1;
        check_restart("release");

        // Minute change mid-frame only affects the following frame.
        wait_tick_sec(30);
        #1;
        MINUTE_in = 7'h35;
        fb = cur_model();
        push_frame(fb);

        wait_frame(1);
        chk("f1_dst17", {63'd0, last_frame[17]}, 64'd1);
        chk("f1_dst18", {63'd0, last_frame[18]}, 64'd0);
        chk("f1_low", 64'({last_frame[19], last_frame[16:0]}), 64'd0);
        chk("f1_start", {63'd0, last_frame[20]}, 64'd1);
        chk("f1_minute", 64'(last_frame[27:21]), 64'h34);
        chk("f1_p1", {63'd0, last_frame[28]}, 64'd1);
        chk("f1_hour", 64'(last_frame[34:29]), 64'h12);
        chk("f1_p2", {63'd0, last_frame[35]}, 64'd0);
        chk("f1_p3", {63'd0, last_frame[58]}, 64'd1);
        chk("f1_frame", 64'(last_frame), 64'(fa));
        #1;
        push_frame(fb);

        wait_frame(2);
        chk("f2_minute", 64'(last_frame[27:21]), 64'h35);
        chk("f2_p1", {63'd0, last_frame[28]}, 64'd0);
        chk("f2_frame", 64'(last_frame), 64'(fb));

        // Abort in the middle of the long pulse of bit 20.
        wait_tick_sec(20);
        #1;
        mon_en = 1'b0;
        repeat (LONG / 4) @(negedge clk);
        #1;
        ENABLE_in = 1'b0;
        @(posedge clk);
        #1;
        chk("dis_dcf", {63'd0, DCF_SIGNAL_out}, 64'd1);
        chk("dis_sec", 64'(SECOND_out), 64'd0);
        chk("dis_tick", {63'd0, SEC_TICK_out}, 64'd0);
        anomalies = 0;
        repeat (3 * LONG) begin
            @(negedge clk);
            if (!DCF_SIGNAL_out || SEC_TICK_out || FRAME_DONE_out || SECOND_out != 6'd0) anomalies++;
        end
        chk("dis_quiet", 64'(anomalies), 64'd0);

        #1;
        exp_q.delete();
        MINUTE_in  = 7'h59;
        HOUR_in    = 6'h23;
        DAY_in     = 6'h31;
        WEEKDAY_in = 3'd7;
        MONTH_in   = 5'h12;
        YEAR_in    = 8'h99;
        DST_in     = 1'b0;
        fc = cur_model();
        push_frame(fc);
        mon_en    = 1'b1;
        ENABLE_in = 1'b1;
        check_restart("reenable");

        wait_frame(3);
        chk("f4_dst17", {63'd0, last_frame[17]}, 64'd0);
        chk("f4_dst18", {63'd0, last_frame[18]}, 64'd1);
        chk("f4_frame", 64'(last_frame), 64'(fc));
        #1;
        push_frame(fc);

        // Asynchronous reset while the sec-3 pulse is low.
        wait_tick_sec(3);
        #3;
        mon_en = 1'b0;
        nReset = 1'b0;
        #1;
        chk("arst_dcf", {63'd0, DCF_SIGNAL_out}, 64'd1);
        chk("arst_sec", 64'(SECOND_out), 64'd0);
        chk("arst_tick", {63'd0, SEC_TICK_out}, 64'd0);
        @(negedge clk);
        #1;
        nReset = 1'b1;
        check_restart("arst_release");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
